// File: rtl/i2c_target_regfile_pkg.sv
// Shared definitions for the I2C target register file.
//   state_e           : protocol FSM states
//   DEV_ADDR_DEFAULT  : default 7-bit target address (HDMI transmitter main map)
//   SDA_FALL/SDA_RISE : {previous, current} synced SDA patterns that mark
//                       START and STOP when SCL is high
package i2c_target_regfile_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_e;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h39;

    localparam logic [1:0] SDA_FALL = 2'b10;
    localparam logic [1:0] SDA_RISE = 2'b01;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Avalon-MM slave bus of the register file (zero-wait combinational read).
//   address    : register index
//   chipselect : access select
//   write_n    : active-low write strobe
//   writedata  : write data, bits [7:0] stored
//   readdata   : {24'b0, reg[address]}
// master modport is the bus owner side, slave modport is the register file.
interface i2c_target_regfile_if #(
    parameter int AW = 4
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/i2c_target_regfile_bus_sync.sv
// Synchronises the raw SCL/SDA pin levels and derives bus events.
//   clk, reset_n      : system clock, async active-low reset
//   scl_in, sda_in    : raw pin levels
//   scl_rise/scl_fall : one-cycle pulses on synced SCL edges
//   start/stop        : one-cycle pulses for START / STOP conditions
//   sda_s             : synced SDA level, aligned with the event pulses
module i2c_bus_sync
    import i2c_target_regfile_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic scl_meta_q, scl_s_q, scl_d_q;
    logic sda_meta_q, sda_s_q, sda_d_q;

    // Reset to the idle bus level (both high) so leaving reset never
    // fabricates an edge or START/STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_d_q    <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_s_q    <= scl_meta_q;
            scl_d_q    <= scl_s_q;
            sda_meta_q <= sda_in;
            sda_s_q    <= sda_meta_q;
            sda_d_q    <= sda_s_q;
        end
    end

    // SCL must be high in both samples so an SDA move right at an SCL edge
    // is not mistaken for START/STOP.
    assign scl_rise = scl_s_q & ~scl_d_q;
    assign scl_fall = ~scl_s_q & scl_d_q;
    assign start    = scl_s_q & scl_d_q & ({sda_d_q, sda_s_q} == SDA_FALL);
    assign stop     = scl_s_q & scl_d_q & ({sda_d_q, sda_s_q} == SDA_RISE);
    assign sda_s    = sda_s_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-pointer register file, also accessible over Avalon-MM.
//   clk, reset_n   : system clock, async active-low reset
//   scl_in, sda_in : I2C pin levels (asynchronous)
//   sda_oe         : 1 = pull SDA low, 0 = release
//   avs            : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   i2c_wr         : one-cycle pulse when an I2C data byte is committed
//   i2c_wr_idx     : register index of that commit
module i2c_target_regfile
    import i2c_target_regfile_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         NREGS    = 16,
    parameter int         AW       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_oe,
    i2c_target_regfile_if.slave  avs,
    output logic                 i2c_wr,
    output logic [AW-1:0]        i2c_wr_idx
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            sda_oe_q, sda_oe_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d;
    logic [7:0]      regs_q [NREGS];
    logic [7:0]      regs_d [NREGS];

    logic [7:0]      rx_byte;
    logic [AW-1:0]   ptr_inc;
    logic [23:0]     unused_wdata_hi;

    assign rx_byte         = {shift_q[6:0], sda_s};
    assign ptr_inc         = ptr_q + AW'(1);
    assign unused_wdata_hi = avs.writedata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_q      <= 1'b0;
            wr_idx_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            wr_q      <= wr_d;
            wr_idx_q  <= wr_idx_d;
            regs_q    <= regs_d;
        end
    end

    // In the ACK states bit_cnt only records whether the ACK clock's rising
    // edge has passed: first SCL fall asserts the ACK, second one ends it.
    // In RDATA each SCL fall presents shift[7] and shifts; the byte's MSB is
    // either placed at the ADDR_ACK exit fall or on the first fall after a
    // master ACK reloads the shift register.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        wr_d      = 1'b0;
        wr_idx_d  = wr_idx_q;
        regs_d    = regs_q;

        if (avs.chipselect && !avs.write_n) begin
            regs_d[avs.address] = avs.writedata[7:0];
        end

        if (stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            rw_d      = rx_byte[0];
                            state_d   = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            ptr_d     = rx_byte[AW-1:0];
                            state_d   = ST_PTR_ACK;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Assigned after the Avalon write so I2C wins a same-index collision.
                            regs_d[ptr_q] = rx_byte;
                            wr_d          = 1'b1;
                            wr_idx_d      = ptr_q;
                            ptr_d         = ptr_inc;
                            bit_cnt_d     = '0;
                            state_d       = ST_WDATA_ACK;
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 3'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RDATA;
                                sda_oe_d = ~regs_q[ptr_q][7];
                                shift_d  = {regs_q[ptr_q][6:0], 1'b0};
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            state_d   = ST_RDATA_ACK;
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_inc;
                            shift_d   = regs_q[ptr_inc];
                            bit_cnt_d = '0;
                            state_d   = ST_RDATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sda_oe       = sda_oe_q;
    assign i2c_wr       = wr_q;
    assign i2c_wr_idx   = wr_idx_q;
    assign avs.readdata = {24'b0, regs_q[avs.address]};

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: bit-banged I2C master model,
// Avalon access tasks, scoreboards for commit indices and read-back bytes.
module tb_i2c_target_regfile;

    localparam int AW = 4;
    localparam int Q  = 80;

    logic       clk;
    logic       reset_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       i2c_wr;
    logic [3:0] i2c_wr_idx;

    i2c_target_regfile_if #(.AW(AW)) avs_if ();

    i2c_target_regfile dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .avs        (avs_if),
        .i2c_wr     (i2c_wr),
        .i2c_wr_idx (i2c_wr_idx)
    );

    assign sda_line = sda_m & ~sda_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         check_count = 0;
    int         pass_count  = 0;
    logic [7:0] model [16];
    logic [3:0] wr_exp_q [$];
    logic [7:0] rd_exp_q [$];
    int         oe_high_cycles = 0;
    int         oe_violations  = 0;
    logic       prev_oe  = 1'b0;
    logic       prev_scl = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Commit monitor: each i2c_wr pulse must match the next expected index.
    always @(negedge clk) begin
        if (reset_n && i2c_wr) begin
            checkOutput("wr_expected", 32'(wr_exp_q.size() != 0), 32'd1);
            if (wr_exp_q.size() != 0) checkOutput("wr_idx", 32'(i2c_wr_idx), 32'(wr_exp_q.pop_front()));
        end
    end

    // SDA drive must never change while SCL is high.
    always @(posedge clk) begin
        if (sda_oe) oe_high_cycles++;
        if (reset_n && scl_m && prev_scl && (sda_oe != prev_oe)) oe_violations++;
        prev_oe  = sda_oe;
        prev_scl = scl_m;
    end

    task automatic write_bit(input logic b, output logic s);
        sda_m = b;     #Q;
        scl_m = 1'b1;  #Q;
        s = sda_line;  #Q;
        scl_m = 1'b0;  #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    // Master writes one byte; acked = target pulled SDA low on the 9th clock.
    task automatic applyStimulus(input logic [7:0] data, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) write_bit(data[i], s);
        write_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic i2c_read_byte(input logic ack_bit, output logic [7:0] data);
        logic s;
        data = '0;
        for (int i = 0; i < 8; i++) begin
            write_bit(1'b1, s);
            data = {data[6:0], s};
        end
        write_bit(ack_bit, s);
    endtask

    task automatic write_and_check(input logic [7:0] data, input logic exp_ack, input string tag);
        logic acked;
        applyStimulus(data, acked);
        checkOutput(tag, 32'(acked), 32'(exp_ack));
    endtask

    task automatic read_and_score(input logic ack_bit, input string tag);
        logic [7:0] got;
        i2c_read_byte(ack_bit, got);
        checkOutput(tag, 32'(rd_exp_q.size() != 0), 32'd1);
        if (rd_exp_q.size() != 0) checkOutput(tag, 32'(got), 32'(rd_exp_q.pop_front()));
    endtask

    task automatic avalon_check(input int idx, input string tag);
        @(negedge clk);
        avs_if.address    = idx[3:0];
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b1;
        #1;
        checkOutput(tag, avs_if.readdata, {24'b0, model[idx]});
        avs_if.chipselect = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acked;
        int   oe_before;
        int   waited;

        reset_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        avs_if.address    = '0;
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
        avs_if.writedata  = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(posedge clk);

        @(negedge clk);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset_i2c_wr", 32'(i2c_wr), 32'd0);
        checkOutput("reset_wr_idx", 32'(i2c_wr_idx), 32'd0);
        avalon_check(0, "reset_reg0");

        // Test 1: pointer write then two data bytes.
        wr_exp_q.push_back(4'd5); wr_exp_q.push_back(4'd6);
        model[5] = 8'hA5; model[6] = 8'h3C;
        i2c_start();
        write_and_check(8'h72, 1'b1, "t1_addr_ack");
        write_and_check(8'h05, 1'b1, "t1_ptr_ack");
        write_and_check(8'hA5, 1'b1, "t1_d0_ack");
        write_and_check(8'h3C, 1'b1, "t1_d1_ack");
        i2c_stop();
        avalon_check(5, "t1_reg5");
        avalon_check(6, "t1_reg6");

        // Test 2: set pointer, repeated start, read two bytes ACK then NACK.
        rd_exp_q.push_back(8'hA5); rd_exp_q.push_back(8'h3C);
        i2c_start();
        write_and_check(8'h72, 1'b1, "t2_addr_ack");
        write_and_check(8'h05, 1'b1, "t2_ptr_ack");
        i2c_rep_start();
        write_and_check(8'h73, 1'b1, "t2_raddr_ack");
        read_and_score(1'b0, "t2_rd0");
        read_and_score(1'b1, "t2_rd1");
        checkOutput("t2_released_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();

        // Test 3: foreign address must be ignored entirely.
        oe_before = oe_high_cycles;
        i2c_start();
        write_and_check(8'h70, 1'b0, "t3_addr_nack");
        write_and_check(8'h00, 1'b0, "t3_ptr_nack");
        write_and_check(8'h5A, 1'b0, "t3_data_nack");
        i2c_stop();
        checkOutput("t3_oe_never", 32'(oe_high_cycles - oe_before), 32'd0);
        avalon_check(0, "t3_reg0");

        // Test 4: pointer wrap on write and on read.
        wr_exp_q.push_back(4'd15); wr_exp_q.push_back(4'd0);
        model[15] = 8'h11; model[0] = 8'h22;
        i2c_start();
        write_and_check(8'h72, 1'b1, "t4_addr_ack");
        write_and_check(8'h0F, 1'b1, "t4_ptr_ack");
        write_and_check(8'h11, 1'b1, "t4_d0_ack");
        write_and_check(8'h22, 1'b1, "t4_d1_ack");
        i2c_stop();
        avalon_check(15, "t4_reg15");
        avalon_check(0, "t4_reg0");
        rd_exp_q.push_back(8'h11); rd_exp_q.push_back(8'h22);
        i2c_start();
        write_and_check(8'h72, 1'b1, "t4r_addr_ack");
        write_and_check(8'h0F, 1'b1, "t4r_ptr_ack");
        i2c_rep_start();
        write_and_check(8'h73, 1'b1, "t4r_raddr_ack");
        read_and_score(1'b0, "t4_rd0");
        read_and_score(1'b1, "t4_rd1");
        i2c_stop();

        // Test 5: Avalon write held on reg3 through the I2C commit to reg3.
        wr_exp_q.push_back(4'd3);
        model[3] = 8'hAA;
        i2c_start();
        write_and_check(8'h72, 1'b1, "t5_addr_ack");
        write_and_check(8'h03, 1'b1, "t5_ptr_ack");
        fork
            begin
                applyStimulus(8'hAA, acked);
                checkOutput("t5_data_ack", 32'(acked), 32'd1);
            end
            begin
                @(negedge clk);
                avs_if.address    = 4'd3;
                avs_if.writedata  = 32'h0000_0055;
                avs_if.chipselect = 1'b1;
                avs_if.write_n    = 1'b0;
                waited = 0;
                while (!i2c_wr && waited < 2000) begin
                    @(negedge clk);
                    waited++;
                end
                avs_if.chipselect = 1'b0;
                avs_if.write_n    = 1'b1;
                checkOutput("t5_commit_seen", 32'(i2c_wr), 32'd1);
            end
        join
        i2c_stop();
        avalon_check(3, "t5_reg3");

        // Test 6: reset while driving a zero data bit.
        i2c_start();
        write_and_check(8'h72, 1'b1, "t6_addr_ack");
        write_and_check(8'h05, 1'b1, "t6_ptr_ack");
        i2c_rep_start();
        write_and_check(8'h73, 1'b1, "t6_raddr_ack");
        write_bit(1'b1, acked);
        checkOutput("t6_driving_bit6", 32'(sda_oe), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkOutput("t6_oe_released", 32'(sda_oe), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        avalon_check(5, "t6_reg5_cleared");
        avalon_check(15, "t6_reg15_cleared");
        wr_exp_q.push_back(4'd2);
        model[2] = 8'h77;
        i2c_start();
        write_and_check(8'h72, 1'b1, "t6_after_addr_ack");
        write_and_check(8'h02, 1'b1, "t6_after_ptr_ack");
        write_and_check(8'h77, 1'b1, "t6_after_data_ack");
        i2c_stop();
        avalon_check(2, "t6_reg2");

        repeat (10) @(posedge clk);
        checkOutput("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        checkOutput("oe_stable_scl_high", 32'(oe_violations), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
